// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared constants and address helper for the ROM read arbiter
package rom_arb_pkg;

    localparam int ROM_ADDR_W = 10;
    localparam int ROM_DATA_W = 32;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

    // Byte address to ROM word index; bits above the ROM depth are dropped.
    function automatic logic [31:0] word_index(input logic [31:0] addr, input int unsigned aw);
        return (addr >> 2) & ((32'd1 << aw) - 32'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with pointer register
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic gnt_id
);

    logic rr_ptr;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && (!req1 || rr_ptr == 1'b0)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign gnt_id = gnt1;

    // The port just served loses the next conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (gnt0 || gnt1) begin
            rr_ptr <= ~gnt_id;
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// rtl/rom_read_arbiter.sv - shares one sync-read ROM between fetch and load ports (option: ROM_ARB_RANGE_CHECK_EN)
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [31:0]       addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [31:0]       addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
`ifdef ROM_ARB_RANGE_CHECK_EN
    output logic              rerr0,
    output logic              rerr1,
`endif
    output logic              rom_ce,
    output logic [31:0]       rom_addr,
    input  logic [DATA_W-1:0] rom_dout
);

    logic        gnt_id;
    logic        any_gnt;
    logic [31:0] addr_sel;
    logic        rsp_valid;
    logic        rsp_id;
    logic        rsp_err;
    logic        sel0;
    logic        sel1;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .gnt_id (gnt_id)
    );

    assign any_gnt  = gnt0 | gnt1;
    assign addr_sel = (gnt_id == PORT_DATA) ? addr1 : addr0;
    assign rom_addr = word_index(addr_sel, ADDR_W);

`ifdef ROM_ARB_RANGE_CHECK_EN
    logic bad_addr;

    // A bad address still burns its grant slot but never touches the ROM.
    assign bad_addr = (addr_sel[31:ADDR_W+2] != '0) || (addr_sel[1:0] != 2'b00);
    assign rom_ce   = any_gnt & ~bad_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= any_gnt;
            rsp_id    <= gnt_id;
            rsp_err   <= any_gnt & bad_addr;
        end
    end

    assign rerr0 = sel0 & rsp_err;
    assign rerr1 = sel1 & rsp_err;
`else
    assign rom_ce  = any_gnt;
    assign rsp_err = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            rsp_valid <= rom_ce;
            rsp_id    <= gnt_id;
        end
    end
`endif

    assign sel0    = rsp_valid && (rsp_id == PORT_IFETCH);
    assign sel1    = rsp_valid && (rsp_id == PORT_DATA);
    assign rvalid0 = sel0;
    assign rvalid1 = sel1;
    assign rdata0  = (sel0 && !rsp_err) ? rom_dout : '0;
    assign rdata1  = (sel1 && !rsp_err) ? rom_dout : '0;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb/tb_rom_read_arbiter.sv - directed self-checking bench for rom_read_arbiter (option: ROM_ARB_RANGE_CHECK_EN)
module tb_rom_read_arbiter;

    logic        clk;
    logic        rst;
    logic        req0;
    logic [31:0] addr0;
    logic        gnt0;
    logic        rvalid0;
    logic [31:0] rdata0;
    logic        req1;
    logic [31:0] addr1;
    logic        gnt1;
    logic        rvalid1;
    logic [31:0] rdata1;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_dout;
`ifdef ROM_ARB_RANGE_CHECK_EN
    logic        rerr0;
    logic        rerr1;
`endif

    int vectors;
    int miscompares;

    rom_read_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .addr0    (addr0),
        .gnt0     (gnt0),
        .rvalid0  (rvalid0),
        .rdata0   (rdata0),
        .req1     (req1),
        .addr1    (addr1),
        .gnt1     (gnt1),
        .rvalid1  (rvalid1),
        .rdata1   (rdata1),
`ifdef ROM_ARB_RANGE_CHECK_EN
        .rerr0    (rerr0),
        .rerr1    (rerr1),
`endif
        .rom_ce   (rom_ce),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM contents: mem[i] = 0x1000 + i, registered read gated by ce.
    always @(posedge clk) begin
        if (rom_ce) rom_dout <= 32'h1000 + {22'd0, rom_addr[9:0]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        addr0 = 32'h0;
        addr1 = 32'h0;
        #12;
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rom_ce", {31'd0, rom_ce}, 32'd0);
        req0 = 1'b1;
        #1;
        chk("rst_gnt0_forced", {31'd0, gnt0}, 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Conflict: both held, grants alternate 0,1,0,1
        tick();
        req0 = 1'b1; addr0 = 32'h0;
        req1 = 1'b1; addr1 = 32'h40;
        #1;
        chk("cf1_gnt0", {31'd0, gnt0}, 32'd1);
        chk("cf1_gnt1", {31'd0, gnt1}, 32'd0);
        chk("cf1_rom_addr", rom_addr, 32'd0);
        tick();
        chk("cf1_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("cf1_rdata0", rdata0, 32'h1000);
        chk("cf1_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("cf2_gnt1", {31'd0, gnt1}, 32'd1);
        chk("cf2_rom_addr", rom_addr, 32'd16);
        tick();
        chk("cf2_rvalid1", {31'd0, rvalid1}, 32'd1);
        chk("cf2_rdata1", rdata1, 32'h1010);
        chk("cf2_rdata0", rdata0, 32'd0);
        chk("cf3_gnt0", {31'd0, gnt0}, 32'd1);
        tick();
        chk("cf3_rdata0", rdata0, 32'h1000);
        chk("cf4_gnt1", {31'd0, gnt1}, 32'd1);
        req0 = 1'b0;
        tick();
        chk("cf4_rvalid1", {31'd0, rvalid1}, 32'd1);
        chk("cf4_rdata1", rdata1, 32'h1010);
        req1 = 1'b0;

        // Pointer hold: port 1 alone, 3 idle cycles, then conflict -> port 0
        tick();
        req1 = 1'b1; addr1 = 32'h40;
        #1;
        chk("ph_gnt1", {31'd0, gnt1}, 32'd1);
        tick();
        req1 = 1'b0;
        chk("ph_rvalid1", {31'd0, rvalid1}, 32'd1);
        tick();
        tick();
        tick();
        chk("ph_idle_rvalid1", {31'd0, rvalid1}, 32'd0);
        req0 = 1'b1; addr0 = 32'h0;
        req1 = 1'b1;
        #1;
        chk("ph_gnt0", {31'd0, gnt0}, 32'd1);
        chk("ph_gnt1_low", {31'd0, gnt1}, 32'd0);
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        tick();

        // Single port streaming
        req0 = 1'b1; addr0 = 32'h0;
        #1;
        chk("sp0_gnt0", {31'd0, gnt0}, 32'd1);
        chk("sp0_rom_ce", {31'd0, rom_ce}, 32'd1);
        tick();
        chk("sp0_rdata0", rdata0, 32'h1000);
        addr0 = 32'h4;
        #1;
        chk("sp1_rom_addr", rom_addr, 32'd1);
        tick();
        chk("sp1_rdata0", rdata0, 32'h1001);
        chk("sp1_rvalid1", {31'd0, rvalid1}, 32'd0);
        addr0 = 32'h8;
        #1;
        chk("sp2_rom_addr", rom_addr, 32'd2);
        tick();
        chk("sp2_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("sp2_rdata0", rdata0, 32'h1002);
        req0 = 1'b0;
        #1;
        chk("sp_idle_rom_ce", {31'd0, rom_ce}, 32'd0);
        tick();
        chk("sp_idle_rvalid0", {31'd0, rvalid0}, 32'd0);

`ifdef ROM_ARB_RANGE_CHECK_EN
        req1 = 1'b1; addr1 = 32'h1000;
        #1;
        chk("rc_oor_gnt1", {31'd0, gnt1}, 32'd1);
        chk("rc_oor_rom_ce", {31'd0, rom_ce}, 32'd0);
        tick();
        chk("rc_oor_rvalid1", {31'd0, rvalid1}, 32'd1);
        chk("rc_oor_rerr1", {31'd0, rerr1}, 32'd1);
        chk("rc_oor_rdata1", rdata1, 32'd0);
        addr1 = 32'h6;
        #1;
        chk("rc_mis_gnt1", {31'd0, gnt1}, 32'd1);
        chk("rc_mis_rom_ce", {31'd0, rom_ce}, 32'd0);
        tick();
        req1 = 1'b0;
        chk("rc_mis_rvalid1", {31'd0, rvalid1}, 32'd1);
        chk("rc_mis_rerr1", {31'd0, rerr1}, 32'd1);
        chk("rc_mis_rdata1", rdata1, 32'd0);
        chk("rc_rerr0", {31'd0, rerr0}, 32'd0);
        tick();
`else
        req0 = 1'b1; addr0 = 32'h1004;
        #1;
        chk("tr_rom_addr", rom_addr, 32'd1);
        tick();
        req0 = 1'b0;
        chk("tr_rdata0", rdata0, 32'h1001);
        tick();
`endif

        // Reset mid-read
        req0 = 1'b1; addr0 = 32'h10;
        #1;
        chk("rm_gnt0", {31'd0, gnt0}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rm_rom_ce_in_rst", {31'd0, rom_ce}, 32'd0);
        tick();
        chk("rm_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rm_rdata0", rdata0, 32'd0);
        chk("rm_rom_ce", {31'd0, rom_ce}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1; addr0 = 32'h0;
        req1 = 1'b1; addr1 = 32'h40;
        #1;
        chk("rm_post_gnt0", {31'd0, gnt0}, 32'd1);
        chk("rm_post_gnt1", {31'd0, gnt1}, 32'd0);
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        chk("rm_post_rdata0", rdata0, 32'h1000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
